load_buffer: RTL and testbench
==============================

# load_buffer

Holds load micro-ops whose effective address has been computed by the address-calculation unit. It issues them in order, one at a time, to the data-memory port and aligns and extends the returned word. It then presents the result on the CDB as an `EX_WR_PACKET` and holds it until the CDB arbiter grants. It sits between the address-calculation unit (producer of `LB_PACKET`) and the CDB arbiter / data-memory port.

## Interface
- `LB_DEPTH`, default 4: number of buffered loads; power of two, ≥2.
- `clock`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-low reset.
- `flush`  in  1  branch-mispredict squash; discards every buffered and in-flight load.
- `lb_packet_in`  in  `LB_PACKET`  load from address unit; fields used: `valid`, `address`, `rd_tag`, `mem_size`, `NPC`, `inst`.
- `lb_full`  out  1  no free entry; the reservation station must not issue a load while high.
- `mem_req_valid`  out  1  read request to data memory.
- `mem_req_addr`  out  `XLEN`  word-aligned address (`address & ~3`).
- `mem_req_ready`  in  1  memory accepts the request this cycle.
- `mem_resp_valid`  in  1  read data valid.
- `mem_resp_data`  in  `XLEN`  full aligned word.
- `lb_result`  out  `EX_WR_PACKET`  CDB candidate: `valid`, `value`, `rob_tag`, `NPC`, `inst`.
- `cdb_grant`  in  1  arbiter consumes `lb_result` this cycle.

## Operation
- Circular FIFO of `LB_DEPTH` entries with head pointer, tail pointer and count (width `$clog2(LB_DEPTH)+1`). Pointers wrap modulo `LB_DEPTH`.
- Enqueue: when `lb_packet_in.valid && !lb_full && !flush`, write the tail entry and increment tail. A valid packet arriving while full is dropped; the bench flags this as an assertion error.
- `lb_full = (count == LB_DEPTH)`, computed from registered count. A same-cycle pop does not permit enqueue into a full buffer.
- FSM states `LB_IDLE`, `LB_WAIT_MEM`, `LB_WAIT_CDB`, `LB_DRAIN`:
  - IDLE: `mem_req_valid = (count != 0)`, with the head address. On `mem_req_ready`, go to WAIT_MEM.
  - WAIT_MEM: on `mem_resp_valid`, register the aligned/extended data, head tag, `NPC` and `inst` into the result register, then go to WAIT_CDB.
  - WAIT_CDB: `lb_result.valid = 1`, held stable. On `cdb_grant`, pop head, clear the result, go to IDLE.
  - DRAIN: wait for the orphaned response, discard it, go to IDLE. No new request is issued in this state.
- Exactly one memory request is outstanding at a time.
- Alignment by `mem_size` (`inst.r.funct3`) with offset `address[1:0]`:
  - LB (000), LBU (100): select the byte at the offset; sign-extend for LB, zero-extend for LBU.
  - LH (001), LHU (101): select the half at `offset[1]`; sign-extend for LH, zero-extend for LHU.
  - LW (010): pass the word through.
  - Any other encoding: output `XLEN'hfacebeec`.
- Flush, taking effect at the next edge:
  - Clear count and pointers; invalidate the result register; drop any simultaneous enqueue.
  - IDLE with request accepted in the flush cycle → DRAIN.
  - WAIT_MEM → DRAIN, or → IDLE if `mem_resp_valid` is high the same cycle.
  - IDLE / WAIT_CDB / DRAIN otherwise → IDLE / IDLE / DRAIN.
- Reset, valid from any state: count and pointers 0, FSM IDLE, `lb_result = '0`, `mem_req_valid = 0`, `lb_full = 0`. Reset overrides flush.

## Timing
- Enqueue at edge N; the request is visible in cycle N+1.
- Earliest response is one cycle after acceptance; `lb_result.valid` rises the cycle after `mem_resp_valid`.
- Minimum enqueue-to-CDB latency is 3 cycles with zero-wait memory and immediate grant.
- Back-to-back throughput is one load per 3 cycles: request, response, grant.
- `lb_result` holds all fields constant while valid and not granted.
- `mem_req_valid`/`mem_req_addr` stay stable until `mem_req_ready`.
- A pop and an enqueue in the same cycle leave count unchanged.

## Structure
- Shared package (`sys_defs`): the existing `LB_PACKET` and `EX_WR_PACKET`; new `LB_STATE` enum; `MEM_SIZE` funct3 constants; default `` `LB_DEPTH ``.
- One combinational sub-module, `load_data_align` (inputs: word, offset, `mem_size`; output: extended value), reusable by a future store-forwarding path.

## Test plan
- Reset with `flush` high: all outputs zero, `lb_full` = 0, no request.
- LB at 0x1003, memory word 0x80FF_1234 → `lb_result.value` = 0xFFFF_FF80 with the correct `rob_tag`. The same load as LBU → 0x0000_0080.
- LH at 0x2002 with word 0x8001_7FFF → 0xFFFF_8001. LW at 0x2000 → 0x8001_7FFF; `mem_req_addr` = 0x2000 in both cases.
- Enqueue 4 loads (`LB_DEPTH` = 4) → `lb_full` = 1. A fifth valid packet is dropped. Results emerge in tag order 1,2,3,4, with `cdb_grant` withheld 5 cycles on load 2 and `lb_result` held stable throughout.
- Flush while in WAIT_MEM with 3 loads queued → FSM enters DRAIN, the late response is discarded, count = 0, and no `lb_result.valid` pulse appears.
- Pointer wrap: 10 sequential loads with random memory latency 1–4 → all complete in order, the count never exceeds 4, and every result value matches the model.

Source files
------------

// File: rtl/load_buffer_pkg.sv
// Shared types and constants for the load buffer: packet layouts, FSM states,
// funct3 load-size encodings and the default depth.
package load_buffer_pkg;

    localparam int XLEN             = 32;
    localparam int ROB_TAG_W        = 5;
    localparam int LB_DEPTH_DEFAULT = 4;

    localparam logic [2:0] MEM_LB  = 3'b000;
    localparam logic [2:0] MEM_LH  = 3'b001;
    localparam logic [2:0] MEM_LW  = 3'b010;
    localparam logic [2:0] MEM_LBU = 3'b100;
    localparam logic [2:0] MEM_LHU = 3'b101;

    localparam logic [XLEN-1:0] BAD_SIZE_VALUE = 32'hfacebeec;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } r_fmt_t;

    typedef union packed {
        logic [31:0] raw;
        r_fmt_t      r;
    } INST;

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      address;
        logic [ROB_TAG_W-1:0] rd_tag;
        logic [2:0]           mem_size;
        logic [XLEN-1:0]      NPC;
        INST                  inst;
    } LB_PACKET;

    // Buffered copy of a load; validity is implied by the FIFO occupancy.
    typedef struct packed {
        logic [XLEN-1:0]      address;
        logic [ROB_TAG_W-1:0] rd_tag;
        logic [2:0]           mem_size;
        logic [XLEN-1:0]      NPC;
        INST                  inst;
    } LB_ENTRY;

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      value;
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [XLEN-1:0]      NPC;
        INST                  inst;
    } EX_WR_PACKET;

    typedef enum logic [1:0] {
        LB_IDLE     = 2'd0,
        LB_WAIT_MEM = 2'd1,
        LB_WAIT_CDB = 2'd2,
        LB_DRAIN    = 2'd3
    } LB_STATE;

endpackage

// File: rtl/load_buffer_if.sv
// Load-buffer boundary: producer packets, data-memory port and CDB candidate.
interface load_buffer_if;
    import load_buffer_pkg::*;

    LB_PACKET          lb_packet_in;
    logic              lb_full;
    logic              mem_req_valid;
    logic [XLEN-1:0]   mem_req_addr;
    logic              mem_req_ready;
    logic              mem_resp_valid;
    logic [XLEN-1:0]   mem_resp_data;
    EX_WR_PACKET       lb_result;
    logic              cdb_grant;

    modport master (
        input  lb_packet_in, mem_req_ready, mem_resp_valid, mem_resp_data, cdb_grant,
        output lb_full, mem_req_valid, mem_req_addr, lb_result
    );

    modport slave (
        output lb_packet_in, mem_req_ready, mem_resp_valid, mem_resp_data, cdb_grant,
        input  lb_full, mem_req_valid, mem_req_addr, lb_result
    );

endinterface

// File: rtl/load_data_align.sv
// Extracts the addressed byte/half/word from an aligned memory word and
// sign- or zero-extends it according to the load's funct3.
module load_data_align
    import load_buffer_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  logic [2:0]      mem_size,
    output logic [XLEN-1:0] value
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection followed by extension.
    always_comb begin
        case (offset)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            default: byte_s = word[31:24];
        endcase

        if (offset[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end

        case (mem_size)
            MEM_LB:  value = {{(XLEN-8){byte_s[7]}}, byte_s};
            MEM_LBU: value = {{(XLEN-8){1'b0}}, byte_s};
            MEM_LH:  value = {{(XLEN-16){half_s[15]}}, half_s};
            MEM_LHU: value = {{(XLEN-16){1'b0}}, half_s};
            MEM_LW:  value = word;
            default: value = BAD_SIZE_VALUE;
        endcase
    end

endmodule

// File: rtl/load_buffer.sv
// In-order load buffer: circular FIFO of address-ready loads, one outstanding
// memory read at a time, result held on the CDB until granted.
module load_buffer
    import load_buffer_pkg::*;
#(
    parameter int LB_DEPTH = LB_DEPTH_DEFAULT
)(
    input  logic           clock,
    input  logic           reset,
    input  logic           flush,
    load_buffer_if.master  lb_if
);

    localparam int PTR_W = $clog2(LB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    LB_ENTRY            entry_r [LB_DEPTH];
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [CNT_W-1:0]   count_r;
    LB_STATE            state_r;
    LB_STATE            state_nxt_s;
    EX_WR_PACKET        result_r;

    logic               full_s;
    logic               push_s;
    logic               pop_s;
    logic               req_valid_s;
    logic               req_fire_s;
    logic [XLEN-1:0]    aligned_s;
    LB_ENTRY            head_s;
    LB_ENTRY            new_entry_s;

    assign full_s      = (count_r == CNT_W'(LB_DEPTH));
    assign head_s      = entry_r[head_r];
    assign push_s      = lb_if.lb_packet_in.valid && !full_s && !flush;
    assign pop_s       = (state_r == LB_WAIT_CDB) && lb_if.cdb_grant && !flush;
    assign req_fire_s  = req_valid_s && lb_if.mem_req_ready;

    assign new_entry_s.address  = lb_if.lb_packet_in.address;
    assign new_entry_s.rd_tag   = lb_if.lb_packet_in.rd_tag;
    assign new_entry_s.mem_size = lb_if.lb_packet_in.mem_size;
    assign new_entry_s.NPC      = lb_if.lb_packet_in.NPC;
    assign new_entry_s.inst     = lb_if.lb_packet_in.inst;

    load_data_align u_align (
        .word     (lb_if.mem_resp_data),
        .offset   (head_s.address[1:0]),
        .mem_size (head_s.mem_size),
        .value    (aligned_s)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= LB_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state; a flush with a read still in flight must drain its response.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            LB_IDLE: begin
                if (flush) begin
                    state_nxt_s = req_fire_s ? LB_DRAIN : LB_IDLE;
                end else if (req_fire_s) begin
                    state_nxt_s = LB_WAIT_MEM;
                end else begin
                    state_nxt_s = LB_IDLE;
                end
            end
            LB_WAIT_MEM: begin
                if (flush) begin
                    state_nxt_s = lb_if.mem_resp_valid ? LB_IDLE : LB_DRAIN;
                end else if (lb_if.mem_resp_valid) begin
                    state_nxt_s = LB_WAIT_CDB;
                end else begin
                    state_nxt_s = LB_WAIT_MEM;
                end
            end
            LB_WAIT_CDB: begin
                if (flush || lb_if.cdb_grant) begin
                    state_nxt_s = LB_IDLE;
                end else begin
                    state_nxt_s = LB_WAIT_CDB;
                end
            end
            LB_DRAIN: begin
                if (lb_if.mem_resp_valid) begin
                    state_nxt_s = LB_IDLE;
                end else begin
                    state_nxt_s = LB_DRAIN;
                end
            end
            default: state_nxt_s = LB_IDLE;
        endcase
    end

    // FSM outputs: a request is offered only from IDLE with something queued.
    always_comb begin
        req_valid_s = 1'b0;
        if (state_r == LB_IDLE) begin
            req_valid_s = (count_r != {CNT_W{1'b0}});
        end else begin
            req_valid_s = 1'b0;
        end
    end

    assign lb_if.mem_req_valid = req_valid_s;
    assign lb_if.mem_req_addr  = {head_s.address[XLEN-1:2], 2'b00};
    assign lb_if.lb_full       = full_s;
    assign lb_if.lb_result     = result_r;

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clock) begin
        if (!reset) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            for (int i = 0; i < LB_DEPTH; i++) begin
                entry_r[i] <= '0;
            end
        end else if (flush) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                entry_r[tail_r] <= new_entry_s;
                tail_r          <= tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // CDB result register: loaded on response, cleared on grant or flush.
    always_ff @(posedge clock) begin
        if (!reset) begin
            result_r <= '0;
        end else if (flush) begin
            result_r <= '0;
        end else if ((state_r == LB_WAIT_MEM) && lb_if.mem_resp_valid) begin
            result_r.valid   <= 1'b1;
            result_r.value   <= aligned_s;
            result_r.rob_tag <= head_s.rd_tag;
            result_r.NPC     <= head_s.NPC;
            result_r.inst    <= head_s.inst;
        end else if (pop_s) begin
            result_r <= '0;
        end
    end

endmodule

// File: tb/tb_load_buffer.sv
// Directed bench for load_buffer: alignment vector table plus hand-written
// full/stall, flush-drain and pointer-wrap sequences.
module tb_load_buffer;
    import load_buffer_pkg::*;

    logic clock = 1'b0;
    logic reset;
    logic flush;

    always #5 clock = ~clock;

    load_buffer_if lb_if();

    load_buffer #(.LB_DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .lb_if (lb_if.master)
    );

    typedef struct {
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] word;
        logic [31:0] expv;
    } vec_t;

    vec_t vecs [11];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clock);
    endtask

    function automatic logic [31:0] npc_of(input logic [4:0] tag);
        return 32'h0000_8000 + {25'd0, tag, 2'b00};
    endfunction

    // Reference alignment written as shift-and-mask.
    function automatic logic [31:0] ref_align(input logic [31:0] w, input logic [1:0] off, input logic [2:0] sz);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (int'(off) * 8)) & 32'h0000_00FF;
        h = (w >> (off[1] ? 16 : 0)) & 32'h0000_FFFF;
        case (sz)
            3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            3'b010:  return w;
            default: return 32'hFACE_BEEC;
        endcase
    endfunction

    task automatic enq(input logic [31:0] addr, input logic [2:0] sz, input logic [4:0] tag);
        lb_if.lb_packet_in.valid    = 1'b1;
        lb_if.lb_packet_in.address  = addr;
        lb_if.lb_packet_in.rd_tag   = tag;
        lb_if.lb_packet_in.mem_size = sz;
        lb_if.lb_packet_in.NPC      = npc_of(tag);
        lb_if.lb_packet_in.inst.raw = {17'd0, sz, 5'd1, 7'b0000011};
        tick;
        lb_if.lb_packet_in = '0;
    endtask

    // Acts as memory for the head load and as CDB arbiter for its result.
    task automatic serve(input logic [31:0] addr, input logic [31:0] word, input logic [4:0] tag,
                         input logic [31:0] expv, input int lat, input int gdelay);
        int n;
        n = 0;
        while (!lb_if.mem_req_valid && n < 20) begin
            tick;
            n++;
        end
        check("req_seen", {31'd0, lb_if.mem_req_valid}, 32'd1);
        check("req_addr", lb_if.mem_req_addr, addr & 32'hFFFF_FFFC);
        lb_if.mem_req_ready = 1'b1;
        tick;
        lb_if.mem_req_ready = 1'b0;
        for (int i = 1; i < lat; i++) begin
            check("no_early_result", {31'd0, lb_if.lb_result.valid}, 32'd0);
            tick;
        end
        lb_if.mem_resp_valid = 1'b1;
        lb_if.mem_resp_data  = word;
        tick;
        lb_if.mem_resp_valid = 1'b0;
        lb_if.mem_resp_data  = 32'd0;
        check("res_valid", {31'd0, lb_if.lb_result.valid}, 32'd1);
        check("res_value", lb_if.lb_result.value, expv);
        check("res_tag", {27'd0, lb_if.lb_result.rob_tag}, {27'd0, tag});
        check("res_npc", lb_if.lb_result.NPC, npc_of(tag));
        for (int i = 0; i < gdelay; i++) begin
            tick;
            check("hold_valid", {31'd0, lb_if.lb_result.valid}, 32'd1);
            check("hold_value", lb_if.lb_result.value, expv);
            check("hold_tag", {27'd0, lb_if.lb_result.rob_tag}, {27'd0, tag});
            check("one_outstanding", {31'd0, lb_if.mem_req_valid}, 32'd0);
        end
        lb_if.cdb_grant = 1'b1;
        tick;
        lb_if.cdb_grant = 1'b0;
        check("res_cleared", {31'd0, lb_if.lb_result.valid}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] waddr [10];
        logic [31:0] wword [10];
        logic [2:0]  wsize [10];
        logic [2:0]  szs   [5];

        vecs[0]  = '{3'b000, 32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80};
        vecs[1]  = '{3'b100, 32'h0000_1003, 32'h80FF_1234, 32'h0000_0080};
        vecs[2]  = '{3'b001, 32'h0000_2002, 32'h8001_7FFF, 32'hFFFF_8001};
        vecs[3]  = '{3'b010, 32'h0000_2000, 32'h8001_7FFF, 32'h8001_7FFF};
        vecs[4]  = '{3'b101, 32'h0000_2000, 32'h8001_7FFF, 32'h0000_7FFF};
        vecs[5]  = '{3'b000, 32'h0000_3001, 32'h1234_5678, 32'h0000_0056};
        vecs[6]  = '{3'b001, 32'h0000_2000, 32'h0000_8000, 32'hFFFF_8000};
        vecs[7]  = '{3'b011, 32'h0000_4000, 32'h1111_1111, 32'hFACE_BEEC};
        vecs[8]  = '{3'b100, 32'h0000_3002, 32'hAABB_CCDD, 32'h0000_00BB};
        vecs[9]  = '{3'b110, 32'h0000_4001, 32'h2222_2222, 32'hFACE_BEEC};
        vecs[10] = '{3'b101, 32'h0000_2002, 32'hFEDC_0000, 32'h0000_FEDC};

        // Reset with flush and a valid packet present: reset wins.
        reset = 1'b0;
        flush = 1'b1;
        lb_if.lb_packet_in          = '0;
        lb_if.lb_packet_in.valid    = 1'b1;
        lb_if.lb_packet_in.address  = 32'h0000_ABCD;
        lb_if.mem_req_ready  = 1'b0;
        lb_if.mem_resp_valid = 1'b0;
        lb_if.mem_resp_data  = 32'd0;
        lb_if.cdb_grant      = 1'b0;
        repeat (3) tick;
        check("reset_result_zero", {31'd0, lb_if.lb_result == '0}, 32'd1);
        check("reset_req_valid", {31'd0, lb_if.mem_req_valid}, 32'd0);
        check("reset_full", {31'd0, lb_if.lb_full}, 32'd0);
        reset = 1'b1;
        flush = 1'b0;
        lb_if.lb_packet_in = '0;
        tick;
        check("post_reset_req", {31'd0, lb_if.mem_req_valid}, 32'd0);

        // Alignment table, zero-wait memory and immediate grant.
        for (int i = 0; i < 11; i++) begin
            enq(vecs[i].addr, vecs[i].size, 5'(i + 1));
            check("req_next_cycle", {31'd0, lb_if.mem_req_valid}, 32'd1);
            serve(vecs[i].addr, vecs[i].word, 5'(i + 1), vecs[i].expv, 1, 0);
        end

        // Fill to full, drop a fifth, drain in order with a stalled grant on tag 2.
        for (int i = 0; i < 4; i++) begin
            enq(32'h0000_5000 + 32'(i * 4), MEM_LW, 5'(i + 1));
        end
        check("full_after_4", {31'd0, lb_if.lb_full}, 32'd1);
        check("req_addr_stable", lb_if.mem_req_addr, 32'h0000_5000);
        enq(32'h0000_5FF0, MEM_LW, 5'd5);
        check("full_after_drop", {31'd0, lb_if.lb_full}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            serve(32'h0000_5000 + 32'(i * 4), 32'hC000_0000 + 32'(i), 5'(i + 1),
                  32'hC000_0000 + 32'(i), 1, (i == 1) ? 5 : 0);
        end
        tick;
        check("fifth_dropped", {31'd0, lb_if.mem_req_valid}, 32'd0);
        check("empty_not_full", {31'd0, lb_if.lb_full}, 32'd0);

        // Flush in WAIT_MEM with three loads queued; the late response is discarded.
        enq(32'h0000_6000, MEM_LW, 5'd6);
        enq(32'h0000_6004, MEM_LW, 5'd7);
        enq(32'h0000_6008, MEM_LW, 5'd8);
        check("flush_req", {31'd0, lb_if.mem_req_valid}, 32'd1);
        lb_if.mem_req_ready = 1'b1;
        tick;
        lb_if.mem_req_ready = 1'b0;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("flush_full", {31'd0, lb_if.lb_full}, 32'd0);
        check("flush_no_req", {31'd0, lb_if.mem_req_valid}, 32'd0);
        enq(32'h0000_7004, MEM_LW, 5'd9);
        check("drain_no_req", {31'd0, lb_if.mem_req_valid}, 32'd0);
        check("drain_no_result", {31'd0, lb_if.lb_result.valid}, 32'd0);
        lb_if.mem_resp_valid = 1'b1;
        lb_if.mem_resp_data  = 32'hDEAD_BEEF;
        tick;
        lb_if.mem_resp_valid = 1'b0;
        lb_if.mem_resp_data  = 32'd0;
        check("orphan_discarded", {31'd0, lb_if.lb_result.valid}, 32'd0);
        serve(32'h0000_7004, 32'h1357_2468, 5'd9, 32'h1357_2468, 2, 0);
        tick;
        check("flush_emptied", {31'd0, lb_if.mem_req_valid}, 32'd0);

        // Pointer wrap: ten loads, random latency, buffer topped up after each pop.
        szs[0] = MEM_LB; szs[1] = MEM_LBU; szs[2] = MEM_LH; szs[3] = MEM_LHU; szs[4] = MEM_LW;
        for (int i = 0; i < 10; i++) begin
            waddr[i] = 32'h0000_9000 + 32'(i * 16) + 32'(i % 4);
            wword[i] = 32'h8C4A_F213 ^ (32'(i) * 32'h1111_1111);
            wsize[i] = szs[i % 5];
        end
        for (int i = 0; i < 4; i++) begin
            enq(waddr[i], wsize[i], 5'(10 + i));
        end
        check("wrap_full", {31'd0, lb_if.lb_full}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            serve(waddr[k], wword[k], 5'(10 + k), ref_align(wword[k], waddr[k][1:0], wsize[k]),
                  int'($urandom_range(1, 4)), k % 2);
            if (k + 4 < 10) begin
                enq(waddr[k + 4], wsize[k + 4], 5'(10 + k + 4));
                check("wrap_refill_full", {31'd0, lb_if.lb_full}, 32'd1);
            end
        end
        tick;
        check("wrap_empty", {31'd0, lb_if.lb_full}, 32'd0);
        check("wrap_no_req", {31'd0, lb_if.mem_req_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
